memory_dumper: RTL and testbench
================================

Name: memory_dumper

Overview:
- Read-side counterpart to the program loader. After execution it walks a contiguous RAM window and streams each word out on a valid/ready interface to the bench, a UART bridge or a checker.
- Sits beside the loader on the RAM port. The system arbiter grants the port to it in a post-EXECUTING dump state.
- Issues one synchronous read per word and holds each word until the consumer accepts it.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 16, RAM word width.
- COUNT_WIDTH, 16, width of the word_count input.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clock).
- start  input  1  begin a dump; sampled in IDLE only.
- base_addr  input  ADDR_WIDTH  first RAM address; sampled with start.
- word_count  input  COUNT_WIDTH  number of words to dump; sampled with start.
- mem_read  output  1  RAM read strobe.
- mem_addr  output  ADDR_WIDTH  RAM read address.
- mem_read_data  input  DATA_WIDTH  RAM data, valid the cycle after mem_read.
- out_valid  output  1  out_addr/out_data hold a word.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high at a clock edge.
- out_addr  output  ADDR_WIDTH  address of the presented word.
- out_data  output  DATA_WIDTH  presented word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: state=IDLE; mem_read=0, mem_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0. Internal cur_addr=0, remaining=0.
- Reset mid-operation aborts the dump immediately. No done pulse. The RAM read is dropped.
- States:
  - IDLE:
    - start=1 and word_count!=0 -> ISSUE. Latch cur_addr=base_addr and remaining=word_count.
    - start=1 and word_count==0 -> DONE.
    - Otherwise stay in IDLE.
  - ISSUE: mem_read=1, mem_addr=cur_addr. Next state CAPTURE. mem_read is high for exactly this one cycle per word.
  - CAPTURE: mem_read=0. At the edge, latch out_data=mem_read_data and out_addr=cur_addr. Next state PRESENT.
  - PRESENT: out_valid=1. out_data and out_addr stay stable while out_ready=0; no timeout. On out_valid&&out_ready:
    - remaining==1 -> DONE.
    - Otherwise -> ISSUE, with remaining-=1 and cur_addr+=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy is decoded from state, with no extra latency.
- Latency: out_valid rises 2 clock edges after the edge that samples start.
- Throughput: 3 cycles per word when out_ready is held high.
- Address arithmetic is modulo 2^ADDR_WIDTH. 16'hFFFF is followed by 16'h0000, with no error flag.
- word_count is treated as unsigned. A dump of 2^COUNT_WIDTH-1 words is legal.
- start asserted while busy is ignored. base_addr and word_count are not re-sampled.
- start held high across DONE->IDLE begins a new dump from the IDLE edge. There is no edge detection.
- out_ready asserted while out_valid=0 has no effect.
- mem_addr holds its last value outside ISSUE.

Test Plan:
- Reset, then preload RAM[0..7]=16'h1000+i. Pulse start with base_addr=0, word_count=8, out_ready=1 -> 8 words out in order, out_addr 0..7, data 1000..1007. Exactly 8 mem_read pulses, 3 cycles apart. done pulses once, 24 cycles after the start edge. busy falls with it.
- Backpressure: word_count=3 and out_ready toggled 0,0,1 per cycle -> each word stays stable during the stall cycles. No duplicated or skipped words. mem_read does not assert during PRESENT.
- Wrap: base_addr=16'hFFFE, word_count=4 -> out_addr sequence FFFE, FFFF, 0000, 0001, carrying the matching RAM contents.
- Zero count: start with word_count=0 -> no mem_read, no out_valid. done high exactly one cycle after the start edge, then IDLE.
- Ignored restart: while busy on a 4-word dump, pulse start with base_addr=16'h0040 -> only the original 4 words are emitted, and exactly one done pulse.
- Async reset: drive reset=0 mid-PRESENT between clock edges -> out_valid, busy and mem_read go to 0 before the next edge. No done pulse. After release, a fresh start works normally.

Source files
------------

// File: rtl/memory_dumper.sv
// Post-execution RAM window dumper.
// Reads one word at a time and streams it out on valid/ready.
module memory_dumper #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_read_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   done_q, done_d;
  logic                   accept;

  assign accept = out_valid_q & out_ready;

  // Next-state and datapath; outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_d     = S_ISSUE;
            cur_addr_d  = base_addr;
            remaining_d = word_count;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_data_d = mem_read_data;
        out_addr_d = cur_addr_q;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (accept) begin
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mem_read_d  = (state_d == S_ISSUE);
    mem_addr_d  = (state_d == S_ISSUE) ? cur_addr_d : mem_addr_q;
    out_valid_d = (state_d == S_PRESENT);
    done_d      = (state_d == S_DONE);
  end

  // State and registered outputs; reset aborts any dump in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper.
// Synchronous RAM model plus edge monitor.
module tb_memory_dumper;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic [15:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  memory_dumper dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] ram [0:65535];

  // Synchronous read: data appears the cycle after mem_read
  always @(posedge clock) begin
    if (mem_read) mem_read_data <= ram[mem_addr];
  end

  int passed = 0;
  int total  = 0;

  int cyc = 0;
  int start_cyc, mr_first, mr_last, vrise, done_rise;
  int mr_cnt, done_cnt, mr_in_present, unstable, stall_cnt;
  logic [15:0] q_addr [$];
  logic [15:0] q_data [$];
  logic        vld_prev, acc_prev;
  logic [15:0] pa, pd;

  // Edge monitor; event cycles are recorded as the edge that raised them
  always @(posedge clock) begin
    if (start && !busy && reset) start_cyc = cyc;
    if (mem_read) begin
      if (mr_cnt == 0) mr_first = cyc - 1;
      mr_last = cyc - 1;
      mr_cnt++;
    end
    if (mem_read && out_valid) mr_in_present++;
    if (out_valid && vrise < 0) vrise = cyc - 1;
    if (done) begin
      done_cnt++;
      done_rise = cyc - 1;
    end
    if (out_valid && !out_ready) stall_cnt++;
    if (vld_prev && !acc_prev) begin
      if (!out_valid || out_addr != pa || out_data != pd) unstable++;
    end
    if (out_valid && out_ready) begin
      q_addr.push_back(out_addr);
      q_data.push_back(out_data);
    end
    vld_prev = out_valid;
    acc_prev = out_valid && out_ready;
    pa = out_addr;
    pd = out_data;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr();
    q_addr.delete();
    q_data.delete();
    start_cyc = -1; mr_first = -1; mr_last = -1;
    vrise = -1; done_rise = -1;
    mr_cnt = 0; done_cnt = 0; mr_in_present = 0;
    unstable = 0; stall_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    @(negedge clock);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (done_cnt >= 1) break;
      @(negedge clock);
    end
    chk(tag, 32'(done_cnt >= 1), 32'd1);
  endtask

  task automatic chk_words(input string tag, input logic [15:0] a0,
                           input int n);
    logic [15:0] a;
    chk({tag, "_count"}, 32'(q_addr.size()), 32'(n));
    a = a0;
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(a));
      chk($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(ram[a]));
      a = a + 16'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 16'h1000 + 16'(i);
    ram[16'hFFFE] = 16'hBEEF;
    ram[16'hFFFF] = 16'hCAFE;
    vld_prev = 1'b0; acc_prev = 1'b0; pa = '0; pd = '0;
    clr();
    reset = 1'b0; start = 1'b0; base_addr = '0;
    word_count = '0; out_ready = 1'b0;
    #12;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 8-word dump with ready held high
    clr();
    out_ready = 1'b1;
    do_start(16'h0000, 16'd8);
    wait_done("seq_done_seen", 60);
    chk_words("seq", 16'h0000, 8);
    chk("seq_mr_cnt", 32'(mr_cnt), 32'd8);
    chk("seq_mr_first", 32'(mr_first - start_cyc), 32'd0);
    chk("seq_mr_span", 32'(mr_last - mr_first), 32'd21);
    chk("seq_valid_lat", 32'(vrise - start_cyc), 32'd2);
    chk("seq_done_lat", 32'(done_rise - start_cyc), 32'd24);
    chk("seq_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    chk("seq_done_once", 32'(done_cnt), 32'd1);

    // Backpressure: ready 0,0,1 while a word is presented
    clr();
    out_ready = 1'b0;
    do_start(16'h0002, 16'd3);
    begin
      int ph;
      ph = 0;
      for (int k = 0; k < 100; k++) begin
        if (done_cnt >= 1) break;
        if (out_valid) begin
          out_ready = (ph == 2);
          ph = (ph == 2) ? 0 : ph + 1;
        end else begin
          out_ready = 1'b0;
          ph = 0;
        end
        @(negedge clock);
      end
    end
    out_ready = 1'b0;
    chk("bp_done_seen", 32'(done_cnt), 32'd1);
    chk_words("bp", 16'h0002, 3);
    chk("bp_stalls", 32'(stall_cnt), 32'd6);
    chk("bp_stable", 32'(unstable), 32'd0);
    chk("bp_mr_in_present", 32'(mr_in_present), 32'd0);
    chk("bp_mr_cnt", 32'(mr_cnt), 32'd3);

    // Address wrap
    clr();
    out_ready = 1'b1;
    do_start(16'hFFFE, 16'd4);
    wait_done("wrap_done_seen", 40);
    chk_words("wrap", 16'hFFFE, 4);

    // Zero count
    repeat (2) @(negedge clock);
    clr();
    do_start(16'h0003, 16'd0);
    chk("zero_done_hi", 32'(done), 32'd1);
    chk("zero_busy_hi", 32'(busy), 32'd1);
    @(negedge clock);
    chk("zero_done_lo", 32'(done), 32'd0);
    chk("zero_busy_lo", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    chk("zero_mr_cnt", 32'(mr_cnt), 32'd0);
    chk("zero_no_valid", 32'(vrise), 32'hFFFF_FFFF);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);

    // Start while busy is ignored
    clr();
    do_start(16'h0004, 16'd4);
    repeat (3) @(negedge clock);
    chk("rs_busy", 32'(busy), 32'd1);
    base_addr  = 16'h0040;
    word_count = 16'd2;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("rs_done_seen", 40);
    repeat (10) @(negedge clock);
    chk_words("rs", 16'h0004, 4);
    chk("rs_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of PRESENT
    clr();
    out_ready = 1'b0;
    do_start(16'h0000, 16'd2);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(negedge clock);
    end
    chk("ar_reach_present", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_mem_read", 32'(mem_read), 32'd0);
    chk("ar_out_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("ar_no_done", 32'(done_cnt), 32'd0);
    clr();
    out_ready = 1'b1;
    do_start(16'h0006, 16'd2);
    wait_done("ar_fresh_done", 30);
    chk_words("ar_fresh", 16'h0006, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
